// File: rtl/ble_ll_pkg.sv
// Shared types and constants for the BLE link-layer deframer.
package ble_ll_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        CRC     = 2'd3
    } state_t;

    localparam logic [23:0] CRC_POLY    = 24'h00065B;
    // Taps of x^7+x^4+1: position 6 feeds back into positions 0 and 4
    localparam logic [6:0]  WHITEN_POLY = 7'h11;
    localparam logic [31:0] AA_ADV      = 32'h8E89BED6;
    localparam int          HDR_BITS    = 16;
    localparam int          CRC_BITS    = 24;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) cnt = cnt + 6'(v[i]);
        return cnt;
    endfunction

    // Bit index == LFSR position; position 1 holds the channel MSB
    function automatic logic [6:0] whiten_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

endpackage

// File: rtl/ble_ll_crc24.sv
// Per-bit dewhitening LFSR and CRC24 LFSR sharing one step strobe.
module ble_ll_crc24
    import ble_ll_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed,
    input  logic [5:0]  chan,
    input  logic        preset,
    input  logic [23:0] crc_init,
    input  logic        step,
    input  logic        crc_en,
    input  logic        dw_en,
    input  logic        din,
    output logic        dout,
    output logic [23:0] crc_q
);
    logic [6:0]  wh_q, wh_d;
    logic [23:0] crc_d;
    logic        fb;

    assign dout = din ^ (wh_q[6] & dw_en);
    assign fb   = crc_q[23] ^ dout;

    always_comb begin
        wh_d  = wh_q;
        crc_d = crc_q;
        if (seed) begin
            wh_d = whiten_seed(chan);
        end else if (step) begin
            wh_d = {wh_q[5:0], 1'b0} ^ (wh_q[6] ? WHITEN_POLY : 7'h00);
        end
        if (preset) begin
            crc_d = crc_init;
        end else if (step && crc_en) begin
            crc_d = {crc_q[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wh_q  <= '0;
            crc_q <= '0;
        end else begin
            wh_q  <= wh_d;
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/ble_ll_deframer.sv
// BLE link-layer deframer: AA correlator, packet FSM, byte assembler and
// CRC status/statistics. Everything advances only on bit_valid.
module ble_ll_deframer
    import ble_ll_pkg::*;
#(
    parameter int NUM_AA      = 2,
    parameter int AA_ERR_TOL  = 0,
    parameter int MAX_PAYLOAD = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic [NUM_AA*32-1:0]  cfg_aa,
    input  logic [5:0]            cfg_chan_idx,
    input  logic [23:0]           cfg_crc_init,
    input  logic                  cfg_dewhiten_en,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  pkt_done,
    output logic                  pkt_crc_ok,
    output logic                  pkt_len_err,
    output logic [1:0]            pkt_aa_idx,
    output logic [15:0]           pkt_count,
    output logic [15:0]           crc_err_count,
    output logic [1:0]            state_dbg
);
    state_t      state_q, state_d;
    logic [31:0] aa_sr_q, aa_sr_d, aa_cand;
    logic [5:0]  hunt_cnt_q, hunt_cnt_d;
    logic [4:0]  ph_cnt_q, ph_cnt_d;
    logic [7:0]  byte_sr_q, byte_sr_d, byte_nxt;
    logic [7:0]  len_q, len_d, pay_cnt_q, pay_cnt_d;
    logic        crc_bad_q, crc_bad_d, dw_en_q, dw_en_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic        done_q, done_d, crc_ok_q, crc_ok_d, len_err_q, len_err_d;
    logic [1:0]  aa_idx_q, aa_idx_d;
    logic [15:0] pkt_count_q, pkt_count_d, crc_err_cnt_q, crc_err_cnt_d;

    logic        aa_hit;
    logic [1:0]  aa_hit_idx;
    logic        wh_seed, crc_preset, lfsr_step, crc_feed, dbit;
    logic [23:0] crc_reg;

    ble_ll_crc24 u_crc (
        .clk      (clk),
        .rst      (rst),
        .seed     (wh_seed),
        .chan     (cfg_chan_idx),
        .preset   (crc_preset),
        .crc_init (cfg_crc_init),
        .step     (lfsr_step),
        .crc_en   (crc_feed),
        .dw_en    (dw_en_q),
        .din      (bit_in),
        .dout     (dbit),
        .crc_q    (crc_reg)
    );

    assign aa_cand  = {bit_in, aa_sr_q[31:1]};
    assign byte_nxt = {dbit, byte_sr_q[7:1]};

    // Walk from the top index down so the lowest matching entry wins
    always_comb begin
        aa_hit     = 1'b0;
        aa_hit_idx = '0;
        for (int i = NUM_AA - 1; i >= 0; i--) begin
            if (popcount32(aa_cand ^ cfg_aa[32*i +: 32]) <= 6'(AA_ERR_TOL)) begin
                aa_hit     = 1'b1;
                aa_hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        aa_sr_d       = aa_sr_q;
        hunt_cnt_d    = hunt_cnt_q;
        ph_cnt_d      = ph_cnt_q;
        byte_sr_d     = byte_sr_q;
        len_d         = len_q;
        pay_cnt_d     = pay_cnt_q;
        crc_bad_d     = crc_bad_q;
        dw_en_d       = dw_en_q;
        out_byte_d    = out_byte_q;
        aa_idx_d      = aa_idx_q;
        pkt_count_d   = pkt_count_q;
        crc_err_cnt_d = crc_err_cnt_q;
        out_valid_d   = 1'b0;
        out_sop_d     = 1'b0;
        out_eop_d     = 1'b0;
        done_d        = 1'b0;
        crc_ok_d      = 1'b0;
        len_err_d     = 1'b0;
        wh_seed       = 1'b0;
        crc_preset    = 1'b0;
        lfsr_step     = 1'b0;
        crc_feed      = 1'b0;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    aa_sr_d = aa_cand;
                    if (hunt_cnt_q != 6'd32) hunt_cnt_d = hunt_cnt_q + 6'd1;
                    if (hunt_cnt_q >= 6'd31 && aa_hit) begin
                        state_d    = HDR;
                        wh_seed    = 1'b1;
                        crc_preset = 1'b1;
                        dw_en_d    = cfg_dewhiten_en;
                        aa_idx_d   = aa_hit_idx;
                        ph_cnt_d   = '0;
                        crc_bad_d  = 1'b0;
                    end
                end
                HDR: begin
                    lfsr_step = 1'b1;
                    crc_feed  = 1'b1;
                    byte_sr_d = byte_nxt;
                    ph_cnt_d  = ph_cnt_q + 5'd1;
                    if (ph_cnt_q[2:0] == 3'd7) begin
                        out_valid_d = 1'b1;
                        out_byte_d  = byte_nxt;
                        if (ph_cnt_q != 5'(HDR_BITS - 1)) begin
                            out_sop_d = 1'b1;
                        end else begin
                            len_d     = byte_nxt;
                            ph_cnt_d  = '0;
                            pay_cnt_d = '0;
                            if ({24'd0, byte_nxt} > 32'(MAX_PAYLOAD)) begin
                                done_d     = 1'b1;
                                len_err_d  = 1'b1;
                                state_d    = HUNT;
                                aa_sr_d    = '0;
                                hunt_cnt_d = '0;
                            end else if (byte_nxt == 8'd0) begin
                                out_eop_d = 1'b1;
                                state_d   = CRC;
                            end else begin
                                state_d = PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    lfsr_step = 1'b1;
                    crc_feed  = 1'b1;
                    byte_sr_d = byte_nxt;
                    ph_cnt_d  = ph_cnt_q + 5'd1;
                    if (ph_cnt_q[2:0] == 3'd7) begin
                        out_valid_d = 1'b1;
                        out_byte_d  = byte_nxt;
                        ph_cnt_d    = '0;
                        pay_cnt_d   = pay_cnt_q + 8'd1;
                        if (pay_cnt_q + 8'd1 == len_q) begin
                            out_eop_d = 1'b1;
                            state_d   = CRC;
                        end
                    end
                end
                CRC: begin
                    // Received CRC arrives MSB-first and is checked bit by bit
                    lfsr_step = 1'b1;
                    crc_bad_d = crc_bad_q | (dbit ^ crc_reg[5'(CRC_BITS - 1) - ph_cnt_q]);
                    ph_cnt_d  = ph_cnt_q + 5'd1;
                    if (ph_cnt_q == 5'(CRC_BITS - 1)) begin
                        done_d     = 1'b1;
                        crc_ok_d   = ~crc_bad_d;
                        state_d    = HUNT;
                        aa_sr_d    = '0;
                        hunt_cnt_d = '0;
                        if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
                        if (crc_bad_d && crc_err_cnt_q != 16'hFFFF)
                            crc_err_cnt_d = crc_err_cnt_q + 16'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            aa_sr_q       <= '0;
            hunt_cnt_q    <= '0;
            ph_cnt_q      <= '0;
            byte_sr_q     <= '0;
            len_q         <= '0;
            pay_cnt_q     <= '0;
            crc_bad_q     <= 1'b0;
            dw_en_q       <= 1'b0;
            out_byte_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            done_q        <= 1'b0;
            crc_ok_q      <= 1'b0;
            len_err_q     <= 1'b0;
            aa_idx_q      <= '0;
            pkt_count_q   <= '0;
            crc_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            aa_sr_q       <= aa_sr_d;
            hunt_cnt_q    <= hunt_cnt_d;
            ph_cnt_q      <= ph_cnt_d;
            byte_sr_q     <= byte_sr_d;
            len_q         <= len_d;
            pay_cnt_q     <= pay_cnt_d;
            crc_bad_q     <= crc_bad_d;
            dw_en_q       <= dw_en_d;
            out_byte_q    <= out_byte_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            done_q        <= done_d;
            crc_ok_q      <= crc_ok_d;
            len_err_q     <= len_err_d;
            aa_idx_q      <= aa_idx_d;
            pkt_count_q   <= pkt_count_d;
            crc_err_cnt_q <= crc_err_cnt_d;
        end
    end

    assign out_byte      = out_byte_q;
    assign out_valid     = out_valid_q;
    assign out_sop       = out_sop_q;
    assign out_eop       = out_eop_q;
    assign pkt_done      = done_q;
    assign pkt_crc_ok    = crc_ok_q;
    assign pkt_len_err   = len_err_q;
    assign pkt_aa_idx    = aa_idx_q;
    assign pkt_count     = pkt_count_q;
    assign crc_err_count = crc_err_cnt_q;
    assign state_dbg     = state_q;

endmodule
